// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Contents: access size, error cause and FSM state enums, plus the
// alignment check used when a request is accepted.
package lsu_pkg;

    localparam int unsigned SIZE_BITS  = 2;
    localparam int unsigned CAUSE_BITS = 2;

    typedef enum logic [SIZE_BITS-1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [CAUSE_BITS-1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_LMISAL = 2'b01,
        CAUSE_SMISAL = 2'b10,
        CAUSE_BUSERR = 2'b11
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_WAIT_R = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    // Only the three low address bits matter; a doubleword is never legal on a 32-bit datapath.
    function automatic logic is_misaligned(input logic [2:0] addr, input size_e size,
                                           input int unsigned xlen);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr[0];
            SZ_W:    mis = |addr[1:0];
            default: mis = (xlen == 32) || (|addr);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bus bundles for the load/store unit.
// lsu_req_if : core <-> lsu request/response (master = core, slave = lsu).
//   req_valid/req_ready handshake, req_we, req_size, req_unsigned, req_addr,
//   req_wdata; resp_valid pulse with resp_rdata, resp_err, resp_cause.
// lsu_mem_if : lsu <-> data memory (master = lsu, slave = memory).
//   mem_valid/mem_ready handshake, mem_we, mem_addr, mem_wstrb, mem_wdata;
//   mem_rvalid with mem_rdata for reads.
interface lsu_req_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic [1:0]        resp_cause;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_cause
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_cause
    );
endinterface

interface lsu_mem_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) ();
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN/8-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports: size/off/uns select the access; wdata -> wstrb + wdata_rep for
// stores; rdata (full memory word) -> rdata_ext (shifted, extended) for loads.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  size_e                       size,
    input  logic [$clog2(XLEN/8)-1:0]   off,
    input  logic                        uns,
    input  logic [XLEN-1:0]             wdata,
    input  logic [XLEN-1:0]             rdata,
    output logic [XLEN/8-1:0]           wstrb,
    output logic [XLEN-1:0]             wdata_rep,
    output logic [XLEN-1:0]             rdata_ext
);

    localparam int unsigned NB = XLEN / 8;

    localparam logic [XLEN-1:0] MASK_B = XLEN'(64'h0000_0000_0000_00FF);
    localparam logic [XLEN-1:0] MASK_H = XLEN'(64'h0000_0000_0000_FFFF);
    localparam logic [XLEN-1:0] MASK_W = XLEN'(64'h0000_0000_FFFF_FFFF);

    logic [NB-1:0]   base;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sbit;

    // Byte-lane enables: a contiguous run of 1<<size lanes starting at the offset.
    always_comb begin
        case (size)
            SZ_B:    base = NB'(1);
            SZ_H:    base = NB'(3);
            SZ_W:    base = NB'(15);
            default: base = '1;
        endcase
        wstrb = base << off;
    end

    // Replicate the low element across the word so every lane carries it.
    always_comb begin
        case (size)
            SZ_B:    wdata_rep = {NB{wdata[7:0]}};
            SZ_H:    wdata_rep = {(NB/2){wdata[15:0]}};
            SZ_W:    wdata_rep = {(NB/4){wdata[31:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    assign shifted = rdata >> {off, 3'b000};

    // Keep the element bits and fill the rest with its sign unless zero-extending.
    always_comb begin
        case (size)
            SZ_B:    begin mask = MASK_B; sbit = shifted[7];  end
            SZ_H:    begin mask = MASK_H; sbit = shifted[15]; end
            SZ_W:    begin mask = MASK_W; sbit = shifted[31]; end
            default: begin mask = '1;     sbit = 1'b0;        end
        endcase
        rdata_ext = (shifted & mask) | ((sbit && !uns) ? ~mask : '0);
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the execute stage and data memory.
// Ports: clk, reset (synchronous, active-high); core (lsu_req_if.slave)
// carries the request and the one-cycle response; mem (lsu_mem_if.master)
// carries the memory request and read return.
// Holds the access FSM, the captured request and the bus timeout counter.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      reset,
    lsu_req_if.slave  core,
    lsu_mem_if.master mem
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              capture;
    logic              misal;

    logic              we_q;
    logic              uns_q;
    size_e             size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;

    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q, resp_err_d;
    cause_e            resp_cause_q, cause_d;
    logic [XLEN-1:0]   resp_rdata_q, rdata_d;

    logic [NB-1:0]     strb_c;
    logic [XLEN-1:0]   wrep_c;
    logic [XLEN-1:0]   rext_c;
    logic              issue;

    lsu_align #(.XLEN(XLEN)) u_align (
        .size      (size_q),
        .off       (addr_q[OFF_W-1:0]),
        .uns       (uns_q),
        .wdata     (wdata_q),
        .rdata     (mem.mem_rdata),
        .wstrb     (strb_c),
        .wdata_rep (wrep_c),
        .rdata_ext (rext_c)
    );

    assign misal = is_misaligned(core.req_addr[2:0], size_e'(core.req_size), XLEN);

    // Next state, timeout count and the response about to be registered.
    // A handshake in the same cycle as the last timeout count wins.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        capture    = 1'b0;
        resp_err_d = 1'b0;
        cause_d    = CAUSE_NONE;
        rdata_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (core.req_valid && req_ready_q) begin
                    capture = 1'b1;
                    if (misal) begin
                        state_d    = ST_RESP;
                        resp_err_d = 1'b1;
                        cause_d    = core.req_we ? CAUSE_SMISAL : CAUSE_LMISAL;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem.mem_ready) begin
                    state_d = we_q ? ST_RESP : ST_WAIT_R;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_RESP;
                    resp_err_d = 1'b1;
                    cause_d    = CAUSE_BUSERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_R: begin
                if (mem.mem_rvalid) begin
                    state_d = ST_RESP;
                    rdata_d = rext_c;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_RESP;
                    resp_err_d = 1'b1;
                    cause_d    = CAUSE_BUSERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered core-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_cause_q <= CAUSE_NONE;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= (state_d == ST_IDLE);
            resp_valid_q <= (state_d == ST_RESP);
            resp_err_q   <= resp_err_d;
            resp_cause_q <= cause_d;
            resp_rdata_q <= rdata_d;
        end
    end

    // Captured request, held for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            we_q    <= core.req_we;
            uns_q   <= core.req_unsigned;
            size_q  <= size_e'(core.req_size);
            addr_q  <= core.req_addr;
            wdata_q <= core.req_wdata;
        end
    end

    // Memory side is decoded from state and captured registers only.
    assign issue         = (state_q == ST_ISSUE);
    assign mem.mem_valid = issue;
    assign mem.mem_we    = issue && we_q;
    assign mem.mem_addr  = issue ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem.mem_wstrb = (issue && we_q) ? strb_c : '0;
    assign mem.mem_wdata = (issue && we_q) ? wrep_c : '0;

    assign core.req_ready  = req_ready_q;
    assign core.resp_valid = resp_valid_q;
    assign core.resp_err   = resp_err_q;
    assign core.resp_cause = resp_cause_q;
    assign core.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: a 32-bit instance (TIMEOUT = 4) and a 64-bit instance.
// Responses are checked against a per-instance expectation queue; cycle
// timing and memory-side signals are checked inline by each test task.
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_req_if #(.XLEN(32), .ADDR_W(32)) r32 ();
    lsu_mem_if #(.XLEN(32), .ADDR_W(32)) m32 ();
    lsu_req_if #(.XLEN(64), .ADDR_W(32)) r64 ();
    lsu_mem_if #(.XLEN(64), .ADDR_W(32)) m64 ();

    lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .reset(reset), .core(r32), .mem(m32)
    );
    lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(16)) dut64 (
        .clk(clk), .reset(reset), .core(r64), .mem(m64)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic [1:0]  cause;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int tests = 0;
    int fails = 0;

    // Scoreboard: every response pulse must match the oldest expectation.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (r32.resp_valid === 1'b1) begin
            tests++;
            if (q32.size() == 0) begin
                fails++;
                $display("FAIL mon32_unexpected: resp_valid=1 rdata=%h with nothing outstanding", r32.resp_rdata);
            end else begin
                e = q32.pop_front();
                if (r32.resp_rdata !== e.rdata[31:0] || r32.resp_err !== e.err || r32.resp_cause !== e.cause) begin
                    fails++;
                    $display("FAIL mon32_resp: got rdata=%h err=%b cause=%b, want rdata=%h err=%b cause=%b",
                             r32.resp_rdata, r32.resp_err, r32.resp_cause, e.rdata[31:0], e.err, e.cause);
                end
            end
        end
    end

    always @(negedge clk) begin : mon64
        exp_t e;
        if (r64.resp_valid === 1'b1) begin
            tests++;
            if (q64.size() == 0) begin
                fails++;
                $display("FAIL mon64_unexpected: resp_valid=1 rdata=%h with nothing outstanding", r64.resp_rdata);
            end else begin
                e = q64.pop_front();
                if (r64.resp_rdata !== e.rdata || r64.resp_err !== e.err || r64.resp_cause !== e.cause) begin
                    fails++;
                    $display("FAIL mon64_resp: got rdata=%h err=%b cause=%b, want rdata=%h err=%b cause=%b",
                             r64.resp_rdata, r64.resp_err, r64.resp_cause, e.rdata, e.err, e.cause);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns in cycle 1 of the access.
    task automatic send32(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        r32.req_valid = 1'b1; r32.req_we = we; r32.req_size = size;
        r32.req_unsigned = uns; r32.req_addr = addr; r32.req_wdata = wdata;
        tick();
        r32.req_valid = 1'b0;
    endtask

    task automatic send64(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [63:0] wdata);
        r64.req_valid = 1'b1; r64.req_we = we; r64.req_size = size;
        r64.req_unsigned = uns; r64.req_addr = addr; r64.req_wdata = wdata;
        tick();
        r64.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests++; if (r32.req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready32: got %b want 0", r32.req_ready); end
        tests++; if (r32.resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp32: got %b want 0", r32.resp_valid); end
        tests++; if (m32.mem_valid !== 1'b0) begin fails++; $display("FAIL reset_mvalid32: got %b want 0", m32.mem_valid); end
        tests++; if (m64.mem_wstrb !== 8'h00) begin fails++; $display("FAIL reset_wstrb64: got %h want 00", m64.mem_wstrb); end
        reset = 1'b0;
        tick();
        tests++; if (r32.req_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready32: got %b want 1", r32.req_ready); end
        tests++; if (r64.req_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready64: got %b want 1", r64.req_ready); end
    endtask

    task automatic test_lb();
        logic [31:0] want [2];
        want[0] = 32'hFFFF_FF80;
        want[1] = 32'h0000_0080;
        for (int i = 0; i < 2; i++) begin
            tests++; if (r32.req_ready !== 1'b1) begin fails++; $display("FAIL lb_ready: got %b want 1", r32.req_ready); end
            q32.push_back('{{32'h0, want[i]}, 1'b0, 2'b00});
            send32(1'b0, 2'b00, i[0], 32'h0000_1003, 32'h0);
            tests++; if (m32.mem_valid !== 1'b1) begin fails++; $display("FAIL lb_mvalid_c1: got %b want 1", m32.mem_valid); end
            tests++; if (m32.mem_addr !== 32'h0000_1000) begin fails++; $display("FAIL lb_maddr: got %h want 00001000", m32.mem_addr); end
            tests++; if (m32.mem_wstrb !== 4'b0000) begin fails++; $display("FAIL lb_wstrb: got %b want 0000", m32.mem_wstrb); end
            m32.mem_ready = 1'b1;
            tick();
            m32.mem_ready = 1'b0;
            tests++; if (m32.mem_valid !== 1'b0) begin fails++; $display("FAIL lb_mvalid_c2: got %b want 0", m32.mem_valid); end
            m32.mem_rvalid = 1'b1; m32.mem_rdata = 32'h80FF_0000;
            tick();
            m32.mem_rvalid = 1'b0;
            tests++; if (r32.resp_valid !== 1'b1) begin fails++; $display("FAIL lb_resp_c3: got %b want 1", r32.resp_valid); end
            tick();
            tests++; if (r32.req_ready !== 1'b1 || r32.resp_valid !== 1'b0) begin
                fails++; $display("FAIL lb_c4: got ready=%b resp=%b want ready=1 resp=0", r32.req_ready, r32.resp_valid);
            end
        end
    endtask

    task automatic test_sh();
        q32.push_back('{64'h0, 1'b0, 2'b00});
        send32(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD);
        tests++; if (m32.mem_we !== 1'b1) begin fails++; $display("FAIL sh_we: got %b want 1", m32.mem_we); end
        tests++; if (m32.mem_addr !== 32'h0000_2000) begin fails++; $display("FAIL sh_maddr: got %h want 00002000", m32.mem_addr); end
        tests++; if (m32.mem_wstrb !== 4'b1100) begin fails++; $display("FAIL sh_wstrb: got %b want 1100", m32.mem_wstrb); end
        tests++; if (m32.mem_wdata !== 32'hABCD_ABCD) begin fails++; $display("FAIL sh_wdata: got %h want abcdabcd", m32.mem_wdata); end
        m32.mem_ready = 1'b1;
        tick();
        m32.mem_ready = 1'b0;
        tests++; if (r32.resp_valid !== 1'b1) begin fails++; $display("FAIL sh_resp_c2: got %b want 1", r32.resp_valid); end
        tick();
    endtask

    task automatic test_misaligned();
        logic        we   [2];
        logic [1:0]  sz   [2];
        logic [31:0] addr [2];
        logic [1:0]  cs   [2];
        we[0] = 1'b0; sz[0] = 2'b10; addr[0] = 32'h0000_1002; cs[0] = 2'b01;
        we[1] = 1'b1; sz[1] = 2'b11; addr[1] = 32'h0000_1000; cs[1] = 2'b10;
        for (int i = 0; i < 2; i++) begin
            q32.push_back('{64'h0, 1'b1, cs[i]});
            send32(we[i], sz[i], 1'b0, addr[i], 32'hFFFF_FFFF);
            tests++; if (r32.resp_valid !== 1'b1) begin fails++; $display("FAIL misal%0d_resp_c1: got %b want 1", i, r32.resp_valid); end
            tests++; if (m32.mem_valid !== 1'b0) begin fails++; $display("FAIL misal%0d_mvalid_c1: got %b want 0", i, m32.mem_valid); end
            tick();
            tests++; if (m32.mem_valid !== 1'b0 || r32.req_ready !== 1'b1) begin
                fails++; $display("FAIL misal%0d_c2: got mvalid=%b ready=%b want 0/1", i, m32.mem_valid, r32.req_ready);
            end
        end
    endtask

    task automatic test_timeout();
        q32.push_back('{64'h0, 1'b1, 2'b11});
        send32(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            tests++; if (m32.mem_valid !== 1'b1 || r32.resp_valid !== 1'b0) begin
                fails++; $display("FAIL timeout_c%0d: got mvalid=%b resp=%b want 1/0", c, m32.mem_valid, r32.resp_valid);
            end
            tick();
        end
        tests++; if (r32.resp_valid !== 1'b1 || m32.mem_valid !== 1'b0) begin
            fails++; $display("FAIL timeout_c5: got resp=%b mvalid=%b want 1/0", r32.resp_valid, m32.mem_valid);
        end
        tick();
        m32.mem_rvalid = 1'b1; m32.mem_rdata = 32'hDEAD_BEEF;
        tick();
        m32.mem_rvalid = 1'b0;
        tests++; if (r32.resp_valid !== 1'b0) begin fails++; $display("FAIL stray_rvalid: got resp=%b want 0", r32.resp_valid); end
        tick();
        // Handshake in the last counted cycle completes normally.
        q32.push_back('{64'h0, 1'b0, 2'b00});
        send32(1'b1, 2'b10, 1'b0, 32'h0000_3004, 32'h5555_AAAA);
        repeat (3) tick();
        tests++; if (m32.mem_wdata !== 32'h5555_AAAA || m32.mem_wstrb !== 4'hF) begin
            fails++; $display("FAIL late_ready_wr: got wdata=%h wstrb=%h want 5555aaaa/f", m32.mem_wdata, m32.mem_wstrb);
        end
        m32.mem_ready = 1'b1;
        tick();
        m32.mem_ready = 1'b0;
        tests++; if (r32.resp_valid !== 1'b1) begin fails++; $display("FAIL late_ready_resp: got %b want 1", r32.resp_valid); end
        tick();
    endtask

    task automatic test_xlen64();
        tests++; if (r64.req_ready !== 1'b1) begin fails++; $display("FAIL ld64_ready: got %b want 1", r64.req_ready); end
        q64.push_back('{64'h8000_0000_0000_0001, 1'b0, 2'b00});
        send64(1'b0, 2'b11, 1'b0, 32'h0000_0010, 64'h0);
        tests++; if (m64.mem_valid !== 1'b1 || m64.mem_addr !== 32'h10) begin
            fails++; $display("FAIL ld64_c1: got mvalid=%b addr=%h want 1/00000010", m64.mem_valid, m64.mem_addr);
        end
        repeat (3) tick();
        m64.mem_ready = 1'b1;
        tick();
        m64.mem_ready = 1'b0;
        tests++; if (m64.mem_valid !== 1'b0 || r64.resp_valid !== 1'b0) begin
            fails++; $display("FAIL ld64_c5: got mvalid=%b resp=%b want 0/0", m64.mem_valid, r64.resp_valid);
        end
        tick();
        m64.mem_rvalid = 1'b1; m64.mem_rdata = 64'h8000_0000_0000_0001;
        tick();
        m64.mem_rvalid = 1'b0;
        tests++; if (r64.resp_valid !== 1'b1) begin fails++; $display("FAIL ld64_resp_c7: got %b want 1", r64.resp_valid); end
        tick();
        // Signed word from the upper half of the doubleword.
        q64.push_back('{64'hFFFF_FFFF_89AB_CDEF, 1'b0, 2'b00});
        send64(1'b0, 2'b10, 1'b0, 32'h0000_0014, 64'h0);
        m64.mem_ready = 1'b1;
        tick();
        m64.mem_ready = 1'b0;
        m64.mem_rvalid = 1'b1; m64.mem_rdata = 64'h89AB_CDEF_0000_0000;
        tick();
        m64.mem_rvalid = 1'b0;
        tests++; if (r64.resp_valid !== 1'b1) begin fails++; $display("FAIL lw64_resp_c3: got %b want 1", r64.resp_valid); end
        tick();
        // Byte store into the top lane.
        q64.push_back('{64'h0, 1'b0, 2'b00});
        send64(1'b1, 2'b00, 1'b0, 32'h0000_0017, 64'h1234_5678_9ABC_DEA5);
        tests++; if (m64.mem_addr !== 32'h10 || m64.mem_wstrb !== 8'h80) begin
            fails++; $display("FAIL sb64_lane: got addr=%h wstrb=%h want 00000010/80", m64.mem_addr, m64.mem_wstrb);
        end
        tests++; if (m64.mem_wdata !== 64'hA5A5_A5A5_A5A5_A5A5) begin fails++; $display("FAIL sb64_wdata: got %h want a5a5a5a5a5a5a5a5", m64.mem_wdata); end
        m64.mem_ready = 1'b1;
        tick();
        m64.mem_ready = 1'b0;
        tests++; if (r64.resp_valid !== 1'b1) begin fails++; $display("FAIL sb64_resp_c2: got %b want 1", r64.resp_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        send32(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
        m32.mem_ready = 1'b1;
        tick();
        m32.mem_ready = 1'b0;
        tests++; if (m32.mem_valid !== 1'b0 || r32.resp_valid !== 1'b0) begin
            fails++; $display("FAIL rmid_wait: got mvalid=%b resp=%b want 0/0", m32.mem_valid, r32.resp_valid);
        end
        reset = 1'b1;
        m32.mem_rvalid = 1'b1; m32.mem_rdata = 32'h1111_2222;
        tick();
        m32.mem_rvalid = 1'b0;
        tests++; if (r32.req_ready !== 1'b0 || r32.resp_valid !== 1'b0 || r32.resp_err !== 1'b0 ||
                     r32.resp_cause !== 2'b00 || r32.resp_rdata !== 32'h0) begin
            fails++; $display("FAIL rmid_core_outs: got ready=%b resp=%b err=%b cause=%b rdata=%h want all 0",
                              r32.req_ready, r32.resp_valid, r32.resp_err, r32.resp_cause, r32.resp_rdata);
        end
        tests++; if (m32.mem_valid !== 1'b0 || m32.mem_we !== 1'b0 || m32.mem_addr !== 32'h0 ||
                     m32.mem_wstrb !== 4'h0 || m32.mem_wdata !== 32'h0) begin
            fails++; $display("FAIL rmid_mem_outs: got valid=%b we=%b addr=%h wstrb=%h wdata=%h want all 0",
                              m32.mem_valid, m32.mem_we, m32.mem_addr, m32.mem_wstrb, m32.mem_wdata);
        end
        reset = 1'b0;
        tick();
        tests++; if (r32.req_ready !== 1'b1 || r32.resp_valid !== 1'b0) begin
            fails++; $display("FAIL rmid_after: got ready=%b resp=%b want 1/0", r32.req_ready, r32.resp_valid);
        end
        repeat (2) tick();
    endtask

    initial begin
        reset = 1'b1;
        r32.req_valid = 1'b0; r32.req_we = 1'b0; r32.req_size = 2'b00;
        r32.req_unsigned = 1'b0; r32.req_addr = '0; r32.req_wdata = '0;
        r64.req_valid = 1'b0; r64.req_we = 1'b0; r64.req_size = 2'b00;
        r64.req_unsigned = 1'b0; r64.req_addr = '0; r64.req_wdata = '0;
        m32.mem_ready = 1'b0; m32.mem_rvalid = 1'b0; m32.mem_rdata = '0;
        m64.mem_ready = 1'b0; m64.mem_rvalid = 1'b0; m64.mem_rdata = '0;

        test_reset();
        test_lb();
        test_sh();
        test_misaligned();
        test_timeout();
        test_xlen64();
        test_reset_mid();

        tests++; if (q32.size() != 0) begin fails++; $display("FAIL q32_drain: got %0d outstanding want 0", q32.size()); end
        tests++; if (q64.size() != 0) begin fails++; $display("FAIL q64_drain: got %0d outstanding want 0", q64.size()); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Parametrised load/store unit placed between the RISC-V core's execute stage and the data memory. It replaces the core's combinational byte/half masking with a handshaked, multi-cycle memory access path. It supports XLEN of 32 or 64, signed and unsigned sub-word loads, byte-lane write strobes, misalignment detection, and a bus timeout. The core stalls while `req_ready` is low and takes results on the `resp_valid` pulse.

## Interface
- XLEN, 32, data width; legal values are 32 and 64.
- ADDR_W, 32, address width.
- TIMEOUT, 255, maximum number of cycles spent waiting in ISSUE or WAIT_R before a bus error is reported; must be ≥1.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  core request.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = B, 01 = H, 10 = W, 11 = D.
- req_unsigned  in  1  zero-extend the load result (LBU/LHU/LWU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  error flag, qualified by resp_valid.
- resp_cause  out  2  00 = none, 01 = load misaligned, 10 = store misaligned, 11 = bus timeout.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory accepts the request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  request address, aligned down to XLEN/8 bytes.
- mem_wstrb  out  XLEN/8  byte-lane write enables; all 0 for loads.
- mem_wdata  out  XLEN  store data, lane-replicated.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data, full word.

## Operation
- FSM states are IDLE, ISSUE, WAIT_R and RESP. The request is captured into registers on `req_valid & req_ready`.
- **IDLE, misaligned request:** if `addr % (1<<size) != 0`, or size is D while XLEN = 32, the next state is RESP with the error flag set and cause 01 (load) or 10 (store). No memory access is made.
- **IDLE, legal request:** the next state is ISSUE.
- **ISSUE:**
  - `mem_valid` = 1.
  - With `off = addr[log2(XLEN/8)-1:0]`, `mem_wstrb = ((1<<(1<<size))-1) << off`.
  - `mem_wdata` is the low `8<<size` bits of `req_wdata` replicated across all lanes.
  - On `mem_ready`: a store goes to RESP; a load goes to WAIT_R.
- **WAIT_R:** on `mem_rvalid`, capture `mem_rdata >> (off*8)`. Extend from bit `(8<<size)-1`: sign-extend, or zero-extend when `req_unsigned` is set. Next state is RESP.
- **Timeout:**
  - The counter clears on entry to ISSUE and on the `mem_ready` handshake.
  - It increments on every cycle spent in ISSUE or WAIT_R.
  - When it reaches TIMEOUT, the next state is RESP with cause 11, and `mem_valid` drops.
  - A `mem_ready` or `mem_rvalid` arriving in the same cycle as the timeout takes priority, and the access completes normally.
- **RESP:** `resp_valid` = 1 for exactly one cycle, then the next state is IDLE.
- `mem_rvalid` is ignored outside WAIT_R. A late response after a timeout is dropped.
- **Reset values:**
  - `req_ready` = 0 during reset and 1 from the first cycle after reset.
  - All other outputs are 0.
  - State is IDLE and the counter is 0.
  - Reset asserted mid-access aborts the access; no response is produced.

## Timing
- Request acceptance is at edge 0.
- `mem_valid` is high in cycle 1.
- **Store:** with `mem_ready` high in cycle 1, `resp_valid` is high in cycle 2. Minimum latency is 2 cycles.
- **Load:** with `mem_ready` in cycle 1 and `mem_rvalid` in cycle 2, `resp_valid` is high in cycle 3. Minimum latency is 3 cycles.
- **Misaligned request:** `resp_valid` is high in cycle 1.
- `req_ready` is low from cycle 1 through the RESP cycle and high again in the cycle after RESP. This gives a throughput of one request per latency + 1 cycles.
- All `mem_*` outputs are registered or decoded from state only, with no combinational path from `req_*`. `resp_*` outputs are registered.

## Structure
- `lsu_pkg` contains:
  - the `size_e` enum (B, H, W, D);
  - the `cause_e` enum (NONE, LMISAL, SMISAL, BUSERR);
  - the `state_e` enum;
  - the `is_misaligned(addr, size, xlen)` function.
- Sub-module `lsu_align` is purely combinational and contains:
  - strobe generation;
  - write-lane replication;
  - read shift and sign/zero extension.
- `lsu` itself holds the FSM, the captured request registers and the timeout counter.

## Test plan
- **LB, XLEN = 32:** addr 0x1003, `mem_rdata` 0x80FF_0000 → `resp_rdata` 0xFFFF_FF80 in cycle 3. With `req_unsigned` set → 0x0000_0080.
- **SH, XLEN = 32:** addr 0x2002, wdata 0x1234_ABCD → `mem_addr` 0x2000, `mem_wstrb` 0b1100, `mem_wdata` 0xABCD_ABCD; `resp_valid` in cycle 2 with `resp_err` 0.
- **LW at 0x1002** → `resp_valid` in cycle 1 with `resp_err` 1 and cause 01; `mem_valid` is never asserted. **SD with XLEN = 32** → `resp_err` 1 with cause 10.
- **Timeout, TIMEOUT = 4:** `mem_ready` held low → `resp_valid` after 4 ISSUE cycles with cause 11. A subsequent stray `mem_rvalid` in IDLE is ignored.
- **LD, XLEN = 64:** addr 0x10, `mem_ready` delayed 3 cycles and `mem_rvalid` 2 cycles after that, rdata 0x8000_0000_0000_0001 → `resp_rdata` identical, no error.
- **Reset mid-access:** reset asserted while in WAIT_R → next cycle all outputs are 0 and no `resp_valid` appears. `req_ready` = 1 in the first cycle after reset deasserts.
